// File: rtl/udp_fdma_pkg.sv
// Shared types and constants for the UDP FIFO -> FDMA DDR write scheduler.
package udp_fdma_pkg;

    localparam int unsigned FDMA_WSIZE_W        = 11;
    localparam int unsigned BYTES_PER_WORD_LOG2 = 2;
    localparam int unsigned RDUSEDW_W           = 12;
    localparam int unsigned DATA_W              = 32;
    localparam int unsigned BURST_CNT_W         = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } sched_state_e;

endpackage

// File: rtl/udp_fdma_ddr_wr_sched_if.sv
// FDMA write-channel bundle: burst command, handshake and write data.
interface udp_fdma_ddr_wr_sched_if
    import udp_fdma_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) ();

    logic [ADDR_W-1:0]       fdma_waddr;
    logic [FDMA_WSIZE_W-1:0] fdma_wsize;
    logic                    fdma_wareq;
    logic                    fdma_wbusy;
    logic                    fdma_wvalid;
    logic [DATA_W-1:0]       fdma_wdata;

    modport master (
        output fdma_waddr,
        output fdma_wsize,
        output fdma_wareq,
        output fdma_wdata,
        input  fdma_wbusy,
        input  fdma_wvalid
    );

    modport slave (
        input  fdma_waddr,
        input  fdma_wsize,
        input  fdma_wareq,
        input  fdma_wdata,
        output fdma_wbusy,
        output fdma_wvalid
    );

endinterface

// File: rtl/udp_fdma_ring_addr.sv
// Circular DDR burst address: advances one slot per burst, wraps at the ring end.
module udp_fdma_ring_addr #(
    parameter int unsigned       ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
    parameter logic [ADDR_W-1:0] RING_BYTES = ADDR_W'(32'h0010_0000),
    parameter logic [ADDR_W-1:0] SLOT_BYTES = ADDR_W'(32'h0000_0400)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              advance,
    output logic [ADDR_W-1:0] addr
);

    localparam logic [ADDR_W-1:0] RING_END = BASE_ADDR + RING_BYTES;

    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;
    logic [ADDR_W-1:0] addr_inc;

    // ring is a whole number of slots, so equality is the only wrap test needed
    always_comb begin
        addr_inc = addr_q + SLOT_BYTES;
        addr_d   = addr_q;
        if (advance) begin
            addr_d = (addr_inc == RING_END) ? BASE_ADDR : addr_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= BASE_ADDR;
        end else begin
            addr_q <= addr_d;
        end
    end

    assign addr = addr_q;

endmodule

// File: rtl/udp_fdma_ddr_wr_sched.sv
// Burst scheduler draining the UDP RX FIFO into a DDR ring through the FDMA write channel.
// Optional partial-burst timeout flush: define UDP_FDMA_WR_FLUSH_EN.
module udp_fdma_ddr_wr_sched
    import udp_fdma_pkg::*;
#(
    parameter int unsigned       BURST_LEN   = 256,
    parameter int unsigned       ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = ADDR_W'(32'h0000_0000),
    parameter logic [ADDR_W-1:0] RING_BYTES  = ADDR_W'(32'h0010_0000),
    parameter int unsigned       TIMEOUT_CYC = 4096
) (
    input  logic                             clkr,
    input  logic                             rrst,
    input  logic                             en,
    input  logic                             rd_rst_done,
    input  logic [RDUSEDW_W-1:0]             rdusedw,
    input  logic [DATA_W-1:0]                fifo_dout,
    input  logic                             fifo_empty,
    output logic                             fifo_re,
    udp_fdma_ddr_wr_sched_if.master          fdma,
    output logic                             burst_done,
    output logic [BURST_CNT_W-1:0]           burst_cnt,
    output logic                             underrun
);

    localparam logic [FDMA_WSIZE_W-1:0] WSIZE_FULL = FDMA_WSIZE_W'(BURST_LEN);
    localparam logic [RDUSEDW_W-1:0]    LEVEL_FULL = RDUSEDW_W'(BURST_LEN);
    localparam logic [ADDR_W-1:0]       SLOT_BYTES = ADDR_W'(BURST_LEN << BYTES_PER_WORD_LOG2);

    if (BURST_LEN == 0 || BURST_LEN > 1024 || TIMEOUT_CYC == 0) begin : g_bad_param
        $error("udp_fdma_ddr_wr_sched: BURST_LEN must be 1..1024, TIMEOUT_CYC >= 1");
    end

    sched_state_e            state_q, state_d;
    logic [FDMA_WSIZE_W-1:0] wsize_q, wsize_d;
    logic [FDMA_WSIZE_W-1:0] wcnt_q, wcnt_d;
    logic                    wareq_q, wareq_d;
    logic                    burst_done_q, burst_done_d;
    logic [BURST_CNT_W-1:0]  burst_cnt_q, burst_cnt_d;
    logic                    underrun_q, underrun_d;

    logic start_full_c;
    logic flush_c;
    logic words_left_c;
    logic advance_c;

    always_comb begin
        start_full_c = (state_q == IDLE) && en && rd_rst_done && (rdusedw >= LEVEL_FULL);
        words_left_c = (wcnt_q != wsize_q);
        advance_c    = (state_q == DONE);
    end

`ifdef UDP_FDMA_WR_FLUSH_EN
    localparam int unsigned              IDLE_CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [IDLE_CNT_W-1:0]    IDLE_LAST  = IDLE_CNT_W'(TIMEOUT_CYC - 1);

    logic [IDLE_CNT_W-1:0] idle_cnt_q, idle_cnt_d;
    logic                  partial_c;

    // counts consecutive idle cycles holding a partial burst; any other cycle restarts it
    always_comb begin
        partial_c  = (state_q == IDLE) && en && rd_rst_done &&
                     (rdusedw != '0) && (rdusedw < LEVEL_FULL);
        idle_cnt_d = '0;
        flush_c    = 1'b0;
        if (partial_c) begin
            if (idle_cnt_q == IDLE_LAST) begin
                flush_c = 1'b1;
            end else begin
                idle_cnt_d = idle_cnt_q + IDLE_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clkr) begin
        if (rrst) begin
            idle_cnt_q <= '0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
        end
    end
`else
    assign flush_c = 1'b0;
`endif

    // next-state and registered-output decode
    always_comb begin
        state_d    = state_q;
        wsize_d    = wsize_q;
        wcnt_d     = wcnt_q;
        underrun_d = underrun_q;

        case (state_q)
            IDLE: begin
                wcnt_d = '0;
                if (start_full_c) begin
                    wsize_d = WSIZE_FULL;
                    state_d = REQ;
                end else if (flush_c) begin
                    wsize_d = FDMA_WSIZE_W'(rdusedw);
                    state_d = REQ;
                end
            end
            REQ: begin
                if (fdma.fdma_wbusy) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (fdma.fdma_wvalid && words_left_c) begin
                    wcnt_d = wcnt_q + FDMA_WSIZE_W'(1);
                end
                if (fdma.fdma_wvalid && fifo_empty) begin
                    underrun_d = 1'b1;
                end
                if (!words_left_c && !fdma.fdma_wbusy) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        wareq_d      = (state_d == REQ);
        burst_done_d = (state_d == DONE);
        burst_cnt_d  = advance_c ? burst_cnt_q + BURST_CNT_W'(1) : burst_cnt_q;
    end

    always_ff @(posedge clkr) begin
        if (rrst) begin
            state_q      <= IDLE;
            wsize_q      <= '0;
            wcnt_q       <= '0;
            wareq_q      <= 1'b0;
            burst_done_q <= 1'b0;
            burst_cnt_q  <= '0;
            underrun_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            wsize_q      <= wsize_d;
            wcnt_q       <= wcnt_d;
            wareq_q      <= wareq_d;
            burst_done_q <= burst_done_d;
            burst_cnt_q  <= burst_cnt_d;
            underrun_q   <= underrun_d;
        end
    end

    udp_fdma_ring_addr #(
        .ADDR_W     (ADDR_W),
        .BASE_ADDR  (BASE_ADDR),
        .RING_BYTES (RING_BYTES),
        .SLOT_BYTES (SLOT_BYTES)
    ) u_ring_addr (
        .clk     (clkr),
        .rst     (rrst),
        .advance (advance_c),
        .addr    (fdma.fdma_waddr)
    );

    // show-ahead data is already valid, so the read strobe follows the FDMA accept directly
    assign fifo_re         = (state_q == DATA) && fdma.fdma_wvalid && !fifo_empty && words_left_c;
    assign fdma.fdma_wdata = fifo_dout;
    assign fdma.fdma_wsize = wsize_q;
    assign fdma.fdma_wareq = wareq_q;
    assign burst_done      = burst_done_q;
    assign burst_cnt       = burst_cnt_q;
    assign underrun        = underrun_q;

endmodule

// File: tb/tb_udp_fdma_ddr_wr_sched.sv
// Directed bench: FIFO and FDMA behavioural models around udp_fdma_ddr_wr_sched.
module tb_udp_fdma_ddr_wr_sched;
    import udp_fdma_pkg::*;

    localparam int unsigned BL = 256;

    logic        clk;
    logic        rrst;
    logic        en;
    logic        rd_rst_done;
    logic [11:0] rdusedw;
    logic [31:0] fifo_dout;
    logic        fifo_empty;
    logic        fifo_re;
    logic        burst_done;
    logic [15:0] burst_cnt;
    logic        underrun;

    udp_fdma_ddr_wr_sched_if #(.ADDR_W(32)) fdma_if ();

    udp_fdma_ddr_wr_sched #(
        .BURST_LEN   (BL),
        .ADDR_W      (32),
        .BASE_ADDR   (32'h0000_0000),
        .RING_BYTES  (32'h0000_0800),
        .TIMEOUT_CYC (16)
    ) dut (
        .clkr        (clk),
        .rrst        (rrst),
        .en          (en),
        .rd_rst_done (rd_rst_done),
        .rdusedw     (rdusedw),
        .fifo_dout   (fifo_dout),
        .fifo_empty  (fifo_empty),
        .fifo_re     (fifo_re),
        .fdma        (fdma_if.master),
        .burst_done  (burst_done),
        .burst_cnt   (burst_cnt),
        .underrun    (underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;

    logic [31:0] fifo_q[$];
    logic [31:0] push_val = 32'hA500_0000;
    logic [31:0] exp_rd   = 32'hA500_0000;
    int          rd_cnt   = 0;
    int          done_cnt = 0;
    int          ord_err  = 0;
    int          rd_base  = 0;
    int          done_base = 0;
    bit          starve   = 1'b0;
    bit          rnd_mode = 1'b0;

    logic        s_re, s_wv, s_wareq, s_done;
    logic [31:0] s_wdata;
    logic [10:0] s_wsize;
    logic [10:0] fd_len;
    int          fd_cnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_words(input int n);
        for (int i = 0; i < n; i++) begin
            fifo_q.push_back(push_val);
            push_val++;
        end
    endtask

    task automatic wait_req(input int lim, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < lim && !seen; i++) begin
            @(negedge clk);
            if (fdma_if.fdma_wareq) seen = 1'b1;
        end
    endtask

    task automatic wait_done(input int lim, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < lim && !seen; i++) begin
            @(negedge clk);
            if (burst_done) seen = 1'b1;
        end
    endtask

    task automatic req_phase(input int id, input logic [31:0] exp_addr, input int exp_wsize);
        bit seen;
        rd_base   = rd_cnt;
        done_base = done_cnt;
        wait_req(100, seen);
        chk($sformatf("b%0d_req_seen", id), 32'(seen), 32'd1);
        chk($sformatf("b%0d_req_addr", id), fdma_if.fdma_waddr, exp_addr);
        chk($sformatf("b%0d_req_wsize", id), 32'(fdma_if.fdma_wsize), exp_wsize);
    endtask

    task automatic done_phase(input int id, input int exp_reads, input logic [31:0] exp_next,
                              input int exp_cnt);
        bit seen;
        wait_done(3000, seen);
        chk($sformatf("b%0d_done_seen", id), 32'(seen), 32'd1);
        @(negedge clk);
        en = 1'b0;
        chk($sformatf("b%0d_reads", id), rd_cnt - rd_base, exp_reads);
        chk($sformatf("b%0d_done_pulses", id), done_cnt - done_base, 32'd1);
        chk($sformatf("b%0d_next_addr", id), fdma_if.fdma_waddr, exp_next);
        chk($sformatf("b%0d_burst_cnt", id), 32'(burst_cnt), exp_cnt);
        chk($sformatf("b%0d_order", id), ord_err, 32'd0);
    endtask

    // outputs are stable mid-cycle; sample them for the models acting after the edge
    always @(negedge clk) begin
        s_re    = fifo_re;
        s_wv    = fdma_if.fdma_wvalid;
        s_wdata = fdma_if.fdma_wdata;
        s_wareq = fdma_if.fdma_wareq;
        s_wsize = fdma_if.fdma_wsize;
        s_done  = burst_done;
    end

    // FIFO read port and FDMA write engine models
    always @(posedge clk) begin
        #1;
        if (s_re) begin
            rd_cnt++;
            if (fifo_q.size() == 0) begin
                ord_err++;
            end else begin
                if (s_wdata !== exp_rd) ord_err++;
                exp_rd++;
                void'(fifo_q.pop_front());
            end
        end
        if (s_done) done_cnt++;

        if (rrst) begin
            fdma_if.fdma_wbusy  = 1'b0;
            fdma_if.fdma_wvalid = 1'b0;
            fd_cnt = 0;
        end else if (!fdma_if.fdma_wbusy) begin
            if (s_wareq) begin
                fdma_if.fdma_wbusy  = 1'b1;
                fdma_if.fdma_wvalid = 1'b0;
                fd_len = s_wsize;
                fd_cnt = 0;
            end
        end else begin
            if (s_wv) fd_cnt++;
            if (fd_cnt == int'(fd_len)) begin
                fdma_if.fdma_wvalid = 1'b0;
                fdma_if.fdma_wbusy  = 1'b0;
            end else begin
                fdma_if.fdma_wvalid = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
            end
        end

        if (starve || fifo_q.size() == 0) begin
            fifo_empty = 1'b1;
            fifo_dout  = 32'h0;
            rdusedw    = starve ? 12'd0 : 12'(fifo_q.size());
        end else begin
            fifo_empty = 1'b0;
            fifo_dout  = fifo_q[0];
            rdusedw    = 12'(fifo_q.size());
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, n_bad=%0d", n_bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  hits;
        int  n;
        bit  ok;
        rrst = 1'b1;
        en = 1'b0;
        rd_rst_done = 1'b0;
        fifo_empty = 1'b1;
        fifo_dout = 32'h0;
        rdusedw = 12'd0;
        fdma_if.fdma_wbusy = 1'b0;
        fdma_if.fdma_wvalid = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_fifo_re",    32'(fifo_re), 32'd0);
        chk("rst_wareq",      32'(fdma_if.fdma_wareq), 32'd0);
        chk("rst_waddr",      fdma_if.fdma_waddr, 32'h0);
        chk("rst_wsize",      32'(fdma_if.fdma_wsize), 32'd0);
        chk("rst_burst_done", 32'(burst_done), 32'd0);
        chk("rst_burst_cnt",  32'(burst_cnt), 32'd0);
        chk("rst_underrun",   32'(underrun), 32'd0);
        chk("rst_state",      32'(dut.state_q), 32'(IDLE));
        rrst = 1'b0;

        // burst 1: held off by rd_rst_done, then one-cycle request latency
        push_words(BL);
        en = 1'b1;
        hits = 0;
        repeat (6) begin
            @(negedge clk);
            if (fdma_if.fdma_wareq) hits++;
        end
        chk("b1_no_req_rd_rst_low", hits, 32'd0);
        rd_base   = rd_cnt;
        done_base = done_cnt;
        rd_rst_done = 1'b1;
        @(negedge clk);
        chk("b1_req_latency", 32'(fdma_if.fdma_wareq), 32'd1);
        chk("b1_req_addr", fdma_if.fdma_waddr, 32'h0);
        chk("b1_req_wsize", 32'(fdma_if.fdma_wsize), 32'd256);
        done_phase(1, 256, 32'h400, 1);

        // burst 2: random FDMA accept gaps
        rnd_mode = 1'b1;
        push_words(BL);
        en = 1'b1;
        req_phase(2, 32'h400, 256);
        done_phase(2, 256, 32'h000, 2);
        chk("b2_no_underrun", 32'(underrun), 32'd0);
        rnd_mode = 1'b0;

        // burst 3: ring wrapped back to the base
        push_words(BL);
        en = 1'b1;
        req_phase(3, 32'h000, 256);
        done_phase(3, 256, 32'h400, 3);

        // burst 4: FIFO starved for 5 accepted beats mid-burst
        push_words(BL);
        en = 1'b1;
        req_phase(4, 32'h400, 256);
        for (int i = 0; i < 2000 && (rd_cnt - rd_base) < 50; i++) @(negedge clk);
        chk("b4_mid_reached", 32'((rd_cnt - rd_base) >= 50), 32'd1);
        starve = 1'b1;
        repeat (5) @(negedge clk);
        starve = 1'b0;
        done_phase(4, 251, 32'h000, 4);
        chk("b4_underrun", 32'(underrun), 32'd1);
        repeat (20) @(negedge clk);
        chk("b4_underrun_sticky", 32'(underrun), 32'd1);

        // burst 5: synchronous reset after 100 words
        push_words(BL - 5);
        en = 1'b1;
        req_phase(5, 32'h000, 256);
        for (int i = 0; i < 2000 && (rd_cnt - rd_base) < 100; i++) @(negedge clk);
        chk("b5_mid_reached", 32'((rd_cnt - rd_base) >= 100), 32'd1);
        rrst = 1'b1;
        en = 1'b0;
        @(negedge clk);
        chk("rrst_state",     32'(dut.state_q), 32'(IDLE));
        chk("rrst_waddr",     fdma_if.fdma_waddr, 32'h0);
        chk("rrst_burst_cnt", 32'(burst_cnt), 32'd0);
        chk("rrst_fifo_re",   32'(fifo_re), 32'd0);
        chk("rrst_wareq",     32'(fdma_if.fdma_wareq), 32'd0);
        chk("rrst_underrun",  32'(underrun), 32'd0);
        rrst = 1'b0;

        // partial fill: 10 words only
        @(negedge clk);
        fifo_q.delete();
        exp_rd = push_val;
        push_words(10);
        en = 1'b1;
        n = 0;
        while (!fdma_if.fdma_wareq && n < 40) begin
            @(negedge clk);
            n++;
        end
`ifdef UDP_FDMA_WR_FLUSH_EN
        chk("flush_req_delay", n, 32'd17);
        chk("flush_wsize", 32'(fdma_if.fdma_wsize), 32'd10);
        chk("flush_addr", fdma_if.fdma_waddr, 32'h0);
        rd_base   = rd_cnt;
        done_base = done_cnt;
        done_phase(6, 10, 32'h400, 1);
`else
        chk("noflush_no_req", 32'(fdma_if.fdma_wareq), 32'd0);
        ok = (burst_cnt == 16'd0);
        chk("noflush_burst_cnt", 32'(ok), 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
